// File: rtl/mw8080_input_pkg.sv
// Shared types and sizing helpers for the Midway 8080 input conditioning stage.
package mw8080_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Frame counters are 4 bits wide, so frame-count parameters may go up to 15.
  localparam int FRAME_CNT_W = 4;

  function automatic int db_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/mw8080_debounce.sv
// One-bit debouncer: the output follows the synchronised input only after it has differed for DB_LEN cycles.
module mw8080_debounce
  import mw8080_input_pkg::*;
#(
  parameter int DB_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = db_width(DB_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mw8080_input_cond.sv
// Input conditioning for the Midway/Taito 8080 cores: sync, debounce, coin pulse stretching, active-low drive.
// Optional autofire on Fire is compiled in with the MW8080_AUTOFIRE_EN macro.
module mw8080_input_cond
  import mw8080_input_pkg::*;
#(
  parameter int DB_LEN          = 64,
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 4,
  parameter int AF_FRAMES       = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic VSync,
  input  logic Coin_in,
  input  logic Start1_in,
  input  logic Start2_in,
  input  logic Fire_in,
  input  logic Left_in,
  input  logic Right_in,
  output logic Coin,
  output logic Sel1Player,
  output logic Sel2Player,
  output logic Fire,
  output logic MoveLeft,
  output logic MoveRight,
  output logic Coin_busy
);

  localparam logic [FRAME_CNT_W-1:0] COIN_LAST = FRAME_CNT_W'(COIN_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] GAP_LAST  = FRAME_CNT_W'(COIN_GAP_FRAMES - 1);

  if (DB_LEN < 2 || COIN_FRAMES < 1 || COIN_FRAMES > 15 || COIN_GAP_FRAMES < 1 ||
      COIN_GAP_FRAMES > 15 || AF_FRAMES < 1 || AF_FRAMES > 15) begin : g_param_check
    $error("mw8080_input_cond: parameter out of range");
  end

  // Bit order: 0 coin, 1 start1, 2 start2, 3 fire, 4 left, 5 right, 6 vsync.
  logic [6:0] raw, sync1, sync2;
  logic       vs_prev, ftick;
  logic [5:0] db;

  assign raw = {VSync, Right_in, Left_in, Fire_in, Start2_in, Start1_in, Coin_in};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1   <= '0;
      sync2   <= '0;
      vs_prev <= 1'b0;
      ftick   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      vs_prev <= sync2[6];
      ftick   <= sync2[6] & ~vs_prev;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_db
    mw8080_debounce #(.DB_LEN(DB_LEN)) u_db (
      .clk  (Clk),
      .rst  (Reset),
      .din  (sync2[i]),
      .dout (db[i])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Sel1Player <= 1'b1;
      Sel2Player <= 1'b1;
      MoveLeft   <= 1'b1;
      MoveRight  <= 1'b1;
    end else begin
      Sel1Player <= ~db[1];
      Sel2Player <= ~db[2];
      MoveLeft   <= ~(db[4] & ~db[5]);
      MoveRight  <= ~(db[5] & ~db[4]);
    end
  end

`ifdef MW8080_AUTOFIRE_EN
  localparam logic [FRAME_CNT_W-1:0] AF_LAST = FRAME_CNT_W'(AF_FRAMES - 1);

  logic [FRAME_CNT_W-1:0] af_cnt;
  logic                   af_on;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      af_cnt <= '0;
      af_on  <= 1'b1;
      Fire   <= 1'b1;
    end else if (!db[3]) begin
      af_cnt <= '0;
      af_on  <= 1'b1;
      Fire   <= 1'b1;
    end else begin
      Fire <= ~af_on;
      if (ftick) begin
        if (af_cnt == AF_LAST) begin
          af_cnt <= '0;
          af_on  <= ~af_on;
        end else begin
          af_cnt <= af_cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Fire <= 1'b1;
    else       Fire <= ~db[3];
  end
`endif

  // A coin held through reset must be released once before it can start a pulse.
  logic [1:0] sync_ok;
  logic       coin_armed, coin_prev, coin_rise;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_ok    <= '0;
      coin_armed <= 1'b0;
      coin_prev  <= 1'b0;
      coin_rise  <= 1'b0;
    end else begin
      sync_ok   <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && !sync2[0]) coin_armed <= 1'b1;
      coin_prev <= db[0];
      coin_rise <= db[0] & ~coin_prev & coin_armed;
    end
  end

  coin_state_t            state;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      Coin      <= 1'b0;
      Coin_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (coin_rise) begin
          state     <= PULSE;
          frame_cnt <= '0;
          Coin      <= 1'b1;
          Coin_busy <= 1'b1;
        end
        PULSE: if (ftick) begin
          if (frame_cnt == COIN_LAST) begin
            state     <= GAP;
            frame_cnt <= '0;
            Coin      <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        GAP: if (ftick) begin
          if (frame_cnt == GAP_LAST) begin
            state     <= IDLE;
            frame_cnt <= '0;
            Coin_busy <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          frame_cnt <= '0;
          Coin      <= 1'b0;
          Coin_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mw8080_input_cond.sv
// Randomised bench for mw8080_input_cond against a window/frame-count reference model.
module tb_mw8080_input_cond;

  localparam int DB_LEN          = 64;
  localparam int COIN_FRAMES     = 3;
  localparam int COIN_GAP_FRAMES = 4;
  localparam int AF_FRAMES       = 4;
  localparam int VS_PERIOD       = 1000;
  localparam int MAXC            = 90000;

  logic Clk = 1'b0, Reset = 1'b1, VSync = 1'b0;
  logic Coin_in = 1'b0, Start1_in = 1'b0, Start2_in = 1'b0;
  logic Fire_in = 1'b0, Left_in = 1'b0, Right_in = 1'b0;
  logic Coin, Sel1Player, Sel2Player, Fire, MoveLeft, MoveRight, Coin_busy;

  mw8080_input_cond #(
    .DB_LEN(DB_LEN), .COIN_FRAMES(COIN_FRAMES),
    .COIN_GAP_FRAMES(COIN_GAP_FRAMES), .AF_FRAMES(AF_FRAMES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .VSync(VSync),
    .Coin_in(Coin_in), .Start1_in(Start1_in), .Start2_in(Start2_in),
    .Fire_in(Fire_in), .Left_in(Left_in), .Right_in(Right_in),
    .Coin(Coin), .Sel1Player(Sel1Player), .Sel2Player(Sel2Player), .Fire(Fire),
    .MoveLeft(MoveLeft), .MoveRight(MoveRight), .Coin_busy(Coin_busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  int cyc = 0, rst_base = 0, vs_phase = 0;

  // hist[n] holds the raw inputs sampled at clock edge n; deb_h/armed_h hold model state after edge n.
  logic [6:0] hist    [MAXC];
  logic [5:0] deb_h   [MAXC];
  logic       armed_h [MAXC];

  logic [5:0] deb;
  logic       armed, in_pulse, in_gap;
  int         ticks_left, af_k;
  logic exp_coin, exp_busy, exp_sel1, exp_sel2, exp_fire, exp_left, exp_right;

  function automatic logic [6:0] raw_at(input int i);
    if (i < rst_base || i < 0) return '0;
    return hist[i];
  endfunction

  function automatic logic [5:0] deb_at(input int i);
    if (i < rst_base || i < 0) return '0;
    return deb_h[i];
  endfunction

  function automatic logic armed_at(input int i);
    if (i < rst_base || i < 0) return 1'b0;
    return armed_h[i];
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input int n);
    logic [6:0] r2, r3, r4, rk;
    logic [5:0] d2, d3, first, eq;
    logic tick, rise;
    r3 = raw_at(n - 3);
    r4 = raw_at(n - 4);
    tick = r3[6] & ~r4[6];
    exp_sel1  = ~deb[1];
    exp_sel2  = ~deb[2];
    exp_left  = ~(deb[4] & ~deb[5]);
    exp_right = ~(deb[5] & ~deb[4]);
`ifdef MW8080_AUTOFIRE_EN
    if (!deb[3]) begin
      exp_fire = 1'b1;
      af_k = 0;
    end else begin
      exp_fire = ((af_k / AF_FRAMES) % 2 == 0) ? 1'b0 : 1'b1;
      if (tick) af_k++;
    end
`else
    exp_fire = ~deb[3];
`endif
    d2 = deb_at(n - 2);
    d3 = deb_at(n - 3);
    rise = d2[0] & ~d3[0] & armed_at(n - 2);
    if (!in_pulse && !in_gap) begin
      if (rise) begin
        in_pulse = 1'b1;
        ticks_left = COIN_FRAMES;
      end
    end else if (tick) begin
      ticks_left--;
      if (ticks_left == 0) begin
        if (in_pulse) begin
          in_pulse = 1'b0;
          in_gap = 1'b1;
          ticks_left = COIN_GAP_FRAMES;
        end else begin
          in_gap = 1'b0;
        end
      end
    end
    exp_coin = in_pulse;
    exp_busy = in_pulse | in_gap;
    r2 = raw_at(n - 2);
    if (n - 2 >= rst_base && !r2[0]) armed = 1'b1;
    armed_h[n] = armed;
    // A bit settles once its last DB_LEN synchronised samples all agree.
    first = r2[5:0];
    eq = '1;
    for (int k = 3; k <= DB_LEN + 1; k++) begin
      rk = raw_at(n - k);
      eq &= ~(rk[5:0] ^ first);
    end
    deb = (deb & ~eq) | (first & eq);
    deb_h[n] = deb;
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("[TB] FAIL cycle_budget at cycle %0d: got overrun, expected < %0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    hist[cyc] = {VSync, Right_in, Left_in, Fire_in, Start2_in, Start1_in, Coin_in};
    if (Reset) begin
      deb_h[cyc] = '0;
      armed_h[cyc] = 1'b0;
      exp_coin = 1'b0; exp_busy = 1'b0;
      {exp_sel1, exp_sel2, exp_fire, exp_left, exp_right} = 5'b11111;
    end else begin
      model_edge(cyc);
    end
    #1;
    checkOutput("coin", Coin, exp_coin);
    checkOutput("coin_busy", Coin_busy, exp_busy);
    checkOutput("sel1", Sel1Player, exp_sel1);
    checkOutput("sel2", Sel2Player, exp_sel2);
    checkOutput("fire", Fire, exp_fire);
    checkOutput("move_left", MoveLeft, exp_left);
    checkOutput("move_right", MoveRight, exp_right);
    VSync = (((cyc + 1 + vs_phase) % VS_PERIOD) < VS_PERIOD / 2);
  endtask

  // ctrl bits: 0 coin, 1 start1, 2 start2, 3 fire, 4 left, 5 right
  task automatic applyStimulus(input logic [5:0] ctrl, input int cycles);
    {Right_in, Left_in, Fire_in, Start2_in, Start1_in, Coin_in} = ctrl;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    #1;
    checkOutput("rst_coin", Coin, 1'b0);
    checkOutput("rst_busy", Coin_busy, 1'b0);
    checkOutput("rst_sel1", Sel1Player, 1'b1);
    checkOutput("rst_sel2", Sel2Player, 1'b1);
    checkOutput("rst_fire", Fire, 1'b1);
    checkOutput("rst_left", MoveLeft, 1'b1);
    checkOutput("rst_right", MoveRight, 1'b1);
    for (int i = 0; i < cycles; i++) step();
    Reset = 1'b0;
    rst_base = cyc + 1;
    deb = '0;
    armed = 1'b0;
    in_pulse = 1'b0;
    in_gap = 1'b0;
    ticks_left = 0;
    af_k = 0;
  endtask

  initial begin
    vs_phase = $urandom_range(VS_PERIOD - 1);
    for (int i = 0; i < 3; i++) step();
    do_reset(3);
    applyStimulus(6'b000000, 100);
    // Fire glitch one cycle short of the debounce length, then a real press.
    applyStimulus(6'b001000, DB_LEN - 1);
    applyStimulus(6'b000000, 100);
    applyStimulus(6'b001000, 150);
    applyStimulus(6'b000000, 100);
    // Contradictory left+right, then right released.
    applyStimulus(6'b110000, 150);
    applyStimulus(6'b010000, 150);
    applyStimulus(6'b000000, 100);
    for (int seg = 0; seg < 16; seg++)
      applyStimulus({5'($urandom), 1'b0}, $urandom_range(20, 140));
    applyStimulus(6'b000000, 200);
    // Single coin press.
    applyStimulus(6'b000001, 200);
    applyStimulus(6'b000000, 8000);
    // Press, second press inside GAP, then a fresh press back in IDLE.
    applyStimulus(6'b000001, 200);
    applyStimulus(6'b000000, 3300);
    applyStimulus(6'b000001, 200);
    applyStimulus(6'b000000, 5000);
    applyStimulus(6'b000001, 200);
    applyStimulus(6'b000000, 8000);
    // Reset mid-pulse with coin held; no pulse until released and pressed again.
    applyStimulus(6'b000001, 1000);
    do_reset(4);
    applyStimulus(6'b000001, 8000);
    applyStimulus(6'b000000, 300);
    applyStimulus(6'b000001, 200);
    applyStimulus(6'b000000, 8000);
`ifdef MW8080_AUTOFIRE_EN
    applyStimulus(6'b001000, 20 * VS_PERIOD + 300);
    applyStimulus(6'b000000, 200);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
